// File: rtl/cv32e40p_instr_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_instr_obi_arbiter
// Purpose  : Shares one OBI instruction memory port between two masters.
//            Master 0 is the prefetch buffer and master 1 is an auxiliary
//            instruction-side requester. Requests are arbitrated either
//            round-robin or with fixed priority to master 0. Responses are
//            routed back through an in-order ID FIFO that records which
//            master owns each outstanding transaction.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_req_i / m0_addr_i       master 0 request and address
//   m0_gnt_o                   master 0 grant
//   m0_rvalid_o / m0_rdata_o   master 0 response valid and read data
//   m0_err_o                   master 0 bus error (valid with m0_rvalid_o)
//   m1_*                       same set for master 1
//   instr_req_o / instr_addr_o request and address towards memory
//   instr_gnt_i                memory grant
//   instr_rvalid_i             memory response valid
//   instr_rdata_i / instr_err_i memory read data and error
//   busy_o                     at least one transaction outstanding
//   outstanding_o              number of outstanding transactions
// ============================================================================
module cv32e40p_instr_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          FIXED_PRIO      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;   // owner ID per slot (0/1)
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [2:0]                 count_q, count_d;
  logic                       lock_q, lock_d;
  logic                       locked_sel_q, locked_sel_d;
  logic                       last_grant_q, last_grant_d;

  // --------------------------------------------------------------------------
  // Combinational arbitration and routing
  // --------------------------------------------------------------------------
  logic can_issue;
  logic sel;
  logic req_sel;
  logic grant;
  logic rsp_valid;
  logic head;

  // Pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    // Only the registered count gates issue: a response popping in the same
    // cycle does not open a slot until the next cycle.
    can_issue = (count_q < MAX_CNT);

    sel = 1'b0;
    if (lock_q) begin
      // A forwarded-but-ungranted request must keep its address stable, so
      // the pending master keeps the port regardless of priority.
      sel = locked_sel_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
      sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end

    req_sel = sel ? m1_req_i : m0_req_i;

    // Nothing is forwarded while reset is held, so every grant stays low.
    instr_req_o  = rst_n & can_issue & req_sel;
    instr_addr_o = sel ? m1_addr_i : m0_addr_i;

    grant    = instr_req_o & instr_gnt_i;
    m0_gnt_o = grant & ~sel;
    m1_gnt_o = grant &  sel;

    // A response with nothing outstanding is a protocol violation; drop it.
    rsp_valid = instr_rvalid_i & (count_q != 3'd0);
    head      = fifo_q[rptr_q];

    m0_rvalid_o = rsp_valid & ~head;
    m1_rvalid_o = rsp_valid &  head;
    m0_err_o    = rsp_valid & ~head & instr_err_i;
    m1_err_o    = rsp_valid &  head & instr_err_i;

    m0_rdata_o = instr_rdata_i;
    m1_rdata_o = instr_rdata_i;

    busy_o        = (count_q != 3'd0);
    outstanding_o = count_q;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;

    if (grant) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = ptr_inc(wptr_q);
      last_grant_d   = sel;
    end

    // The response always belongs to the oldest entry, even when a new
    // entry is pushed in the same cycle.
    if (rsp_valid) begin
      rptr_d = ptr_inc(rptr_q);
    end

    unique case ({grant, rsp_valid})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Lock while the request is visible but unaccepted. If the locked master
    // withdraws its request, instr_req_o drops and the lock releases.
    lock_d       = instr_req_o & ~instr_gnt_i;
    locked_sel_d = lock_d ? sel : locked_sel_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= 3'd0;
      lock_q       <= 1'b0;
      locked_sel_q <= 1'b0;
      // Seeded to master 1 so that master 0 wins the first tie.
      last_grant_q <= 1'b1;
    end else begin
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      locked_sel_q <= locked_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
`ifdef CV32E40P_ASSERT_ON
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 4)) begin : g_param_check
    $error("MAX_OUTSTANDING must be in the range 1..4");
  end

  a_no_rvalid_when_empty : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && (count_q == 3'd0)))
    else $error("instr_rvalid_i asserted with no outstanding transaction");

  a_count_in_range : assert property (
    @(posedge clk) disable iff (!rst_n)
    count_q <= MAX_CNT)
    else $error("outstanding count exceeds MAX_OUTSTANDING");

  a_locked_master_requesting : assert property (
    @(posedge clk) disable iff (!rst_n)
    lock_q |-> req_sel)
    else $error("locked master withdrew its request before grant");
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_instr_obi_arbiter
// Purpose  : Self-checking bench. Drives two arbiter instances (round-robin
//            and fixed-priority) with identical directed stimulus and checks
//            both against a queue-based model every cycle, plus hand-computed
//            expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_instr_obi_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  logic        o_req     [2];
  logic [31:0] o_addr    [2];
  logic        o_m0_gnt  [2];
  logic        o_m1_gnt  [2];
  logic        o_m0_rv   [2];
  logic        o_m1_rv   [2];
  logic        o_m0_err  [2];
  logic        o_m1_err  [2];
  logic [31:0] o_m0_rdata[2];
  logic [31:0] o_m1_rdata[2];
  logic        o_busy    [2];
  logic [2:0]  o_out     [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance 0: round-robin. Instance 1: fixed priority to master 0.
  for (genvar d = 0; d < 2; d++) begin : g_dut
    cv32e40p_instr_obi_arbiter #(
      .MAX_OUTSTANDING(MAXO),
      .FIXED_PRIO     (d == 1)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m0_req_i      (m0_req),
      .m0_addr_i     (m0_addr),
      .m0_gnt_o      (o_m0_gnt[d]),
      .m0_rvalid_o   (o_m0_rv[d]),
      .m0_rdata_o    (o_m0_rdata[d]),
      .m0_err_o      (o_m0_err[d]),
      .m1_req_i      (m1_req),
      .m1_addr_i     (m1_addr),
      .m1_gnt_o      (o_m1_gnt[d]),
      .m1_rvalid_o   (o_m1_rv[d]),
      .m1_rdata_o    (o_m1_rdata[d]),
      .m1_err_o      (o_m1_err[d]),
      .instr_req_o   (o_req[d]),
      .instr_addr_o  (o_addr[d]),
      .instr_gnt_i   (gnt),
      .instr_rvalid_i(rvalid),
      .instr_rdata_i (rdata),
      .instr_err_i   (err),
      .busy_o        (o_busy[d]),
      .outstanding_o (o_out[d])
    );
  end

  task automatic chk(input string name, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: owner queue per instance, last winner, pending (locked) master.
  // --------------------------------------------------------------------------
  int oq     [2][$];
  int last_g [2];
  int pend   [2];
  int e_sel  [2];
  bit e_req  [2];
  bit e_pop  [2];

  task automatic model_check(input int d);
    int cnt;
    int sel;
    int head;
    bit ereq;
    bit epop;
    if (!rst_n) begin
      oq[d].delete();
      last_g[d] = 1;
      pend[d]   = -1;
    end
    cnt = oq[d].size();
    if (pend[d] >= 0)              sel = pend[d];
    else if (m0_req && !m1_req)    sel = 0;
    else if (m1_req && !m0_req)    sel = 1;
    else if (m0_req && m1_req)     sel = (d == 1) ? 0 : 1 - last_g[d];
    else                           sel = 0;
    ereq = rst_n && (cnt < MAXO) && ((sel == 0) ? m0_req : m1_req);
    epop = rst_n && rvalid && (cnt > 0);
    head = epop ? oq[d][0] : -1;

    chk("instr_req",  d, 32'(o_req[d]),    32'(ereq));
    if (ereq) chk("instr_addr", d, o_addr[d], (sel == 0) ? m0_addr : m1_addr);
    chk("m0_gnt",     d, 32'(o_m0_gnt[d]), 32'(ereq && gnt && sel == 0));
    chk("m1_gnt",     d, 32'(o_m1_gnt[d]), 32'(ereq && gnt && sel == 1));
    chk("m0_rvalid",  d, 32'(o_m0_rv[d]),  32'(head == 0));
    chk("m1_rvalid",  d, 32'(o_m1_rv[d]),  32'(head == 1));
    chk("m0_err",     d, 32'(o_m0_err[d]), 32'(head == 0 && err));
    chk("m1_err",     d, 32'(o_m1_err[d]), 32'(head == 1 && err));
    chk("m0_rdata",   d, o_m0_rdata[d],    rdata);
    chk("m1_rdata",   d, o_m1_rdata[d],    rdata);
    chk("busy",       d, 32'(o_busy[d]),   32'(cnt != 0));
    chk("outstanding",d, 32'(o_out[d]),    32'(cnt));

    e_sel[d] = sel;
    e_req[d] = ereq;
    e_pop[d] = epop;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_check(d);
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        if (e_pop[d]) void'(oq[d].pop_front());
        if (e_req[d] && gnt) begin
          oq[d].push_back(e_sel[d]);
          last_g[d] = e_sel[d];
        end
        pend[d] = (e_req[d] && !gnt) ? e_sel[d] : -1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 32'h0;
  endtask

  task automatic do_reset();
    step();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      last_g[d] = 1; pend[d] = -1; e_sel[d] = 0; e_req[d] = 0; e_pop[d] = 0;
    end
    rst_n = 1'b0;
    idle();
    m0_addr = 32'h0; m1_addr = 32'h0;
    // Requests and grant held high during reset must not leak through.
    m0_req = 1'b1; m0_addr = 32'h0000_1000; gnt = 1'b1;
    at_neg(); at_neg();
    chk("rst instr_req", 0, 32'(o_req[0]),    32'd0);
    chk("rst m0_gnt",    0, 32'(o_m0_gnt[0]), 32'd0);
    chk("rst busy",      0, 32'(o_busy[0]),   32'd0);
    step();
    rst_n = 1'b1;
    idle();
    step();

    // ---- single master 0 transaction ----
    m0_req = 1'b1; m0_addr = 32'h0000_1000; gnt = 1'b1;
    at_neg();
    chk("T1 m0_gnt",  0, 32'(o_m0_gnt[0]), 32'd1);
    chk("T1 addr",    0, o_addr[0],        32'h0000_1000);
    chk("T1 out0",    0, 32'(o_out[0]),    32'd0);
    step();
    idle(); rvalid = 1'b1; rdata = 32'h0000_0013;
    at_neg();
    chk("T1 m0_rv",   0, 32'(o_m0_rv[0]),  32'd1);
    chk("T1 rdata",   0, o_m0_rdata[0],    32'h0000_0013);
    chk("T1 m1_rv",   0, 32'(o_m1_rv[0]),  32'd0);
    chk("T1 out1",    0, 32'(o_out[0]),    32'd1);
    step();
    idle();
    at_neg();
    chk("T1 out2",    0, 32'(o_out[0]),    32'd0);

    // ---- lock: m0 waits 3 cycles, m1 joins; RR would otherwise pick m1 ----
    step();
    m0_req = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
    at_neg();
    chk("L c0 addr",  0, o_addr[0], 32'h100);
    chk("L c0 req",   0, 32'(o_req[0]), 32'd1);
    step();
    m1_req = 1'b1;
    at_neg();
    chk("L c1 addr",  0, o_addr[0], 32'h100);
    chk("L c1 m1gnt", 0, 32'(o_m1_gnt[0]), 32'd0);
    step();
    at_neg();
    chk("L c2 addr",  0, o_addr[0], 32'h100);
    step();
    gnt = 1'b1;
    at_neg();
    chk("L c3 addr",  0, o_addr[0], 32'h100);
    chk("L c3 m0gnt", 0, 32'(o_m0_gnt[0]), 32'd1);
    chk("L c3 m1gnt", 0, 32'(o_m1_gnt[0]), 32'd0);
    step();
    m0_req = 1'b0;
    at_neg();
    chk("L c4 m1gnt", 0, 32'(o_m1_gnt[0]), 32'd1);
    chk("L c4 addr",  0, o_addr[0], 32'h200);
    step();
    // ---- response for m0, then simultaneous grant + response with error ----
    idle(); rvalid = 1'b1; rdata = 32'h55;
    at_neg();
    chk("S m0_rv",    0, 32'(o_m0_rv[0]), 32'd1);
    chk("S out",      0, 32'(o_out[0]),   32'd2);
    step();
    m0_req = 1'b1; m0_addr = 32'h300; gnt = 1'b1; rvalid = 1'b1; err = 1'b1; rdata = 32'h66;
    at_neg();
    chk("S m1_rv",    0, 32'(o_m1_rv[0]),  32'd1);
    chk("S m1_err",   0, 32'(o_m1_err[0]), 32'd1);
    chk("S m0_rv",    0, 32'(o_m0_rv[0]),  32'd0);
    chk("S m0_gnt",   0, 32'(o_m0_gnt[0]), 32'd1);
    step();
    idle();
    at_neg();
    chk("S out1",     0, 32'(o_out[0]),    32'd1);
    step();
    rvalid = 1'b1;
    at_neg();
    chk("S head m0",  0, 32'(o_m0_rv[0]),  32'd1);
    chk("S m0_err",   0, 32'(o_m0_err[0]), 32'd0);

    // ---- both request, memory always grants ----
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'hA0; m1_addr = 32'hB0; gnt = 1'b1;
    at_neg();
    chk("RR g0 m0",   0, 32'(o_m0_gnt[0]), 32'd1);
    chk("FP g0 m0",   1, 32'(o_m0_gnt[1]), 32'd1);
    step();
    at_neg();
    chk("RR g1 m1",   0, 32'(o_m1_gnt[0]), 32'd1);
    chk("RR g1 addr", 0, o_addr[0],        32'hB0);
    chk("FP g1 m0",   1, 32'(o_m0_gnt[1]), 32'd1);
    step();
    at_neg();
    chk("RR full",    0, 32'(o_req[0]),    32'd0);
    chk("FP full",    1, 32'(o_req[1]),    32'd0);
    chk("RR out2",    0, 32'(o_out[0]),    32'd2);
    step();
    idle(); rvalid = 1'b1; rdata = 32'h1;
    at_neg();
    chk("RR r0 m0",   0, 32'(o_m0_rv[0]), 32'd1);
    step();
    at_neg();
    chk("RR r1 m1",   0, 32'(o_m1_rv[0]), 32'd1);
    chk("FP r1 m0",   1, 32'(o_m0_rv[1]), 32'd1);
    step();
    // steady alternation with a response every cycle
    idle(); m0_req = 1'b1; m1_req = 1'b1; gnt = 1'b1;
    at_neg();
    chk("A0 m0gnt",   0, 32'(o_m0_gnt[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      rvalid = 1'b1; rdata = 32'(i + 32'h40);
      at_neg();
    end
    chk("A3 m1gnt",   0, 32'(o_m1_gnt[0]), 32'd1);
    chk("A3 m0rv",    0, 32'(o_m0_rv[0]),  32'd1);
    chk("FP A3 m1",   1, 32'(o_m1_gnt[1]), 32'd0);
    step();
    idle(); rvalid = 1'b1;
    at_neg();
    chk("A4 m1rv",    0, 32'(o_m1_rv[0]),  32'd1);

    // ---- fixed priority: pop does not free a slot; m1 only when m0 idle ----
    step();
    idle(); m0_req = 1'b1; m1_req = 1'b1; gnt = 1'b1;
    step();
    at_neg();
    step();
    rvalid = 1'b1;
    at_neg();
    chk("FP popblk",  1, 32'(o_req[1]),    32'd0);
    chk("FP out2",    1, 32'(o_out[1]),    32'd2);
    step();
    at_neg();
    chk("FP regnt",   1, 32'(o_m0_gnt[1]), 32'd1);
    step();
    m0_req = 1'b0;
    at_neg();
    chk("FP m1gnt",   1, 32'(o_m1_gnt[1]), 32'd1);

    // ---- reset with two outstanding, then a stray response ----
    step();
    rvalid = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    at_neg();
    step();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("R busy",   d, 32'(o_busy[d]),   32'd0);
      chk("R out",    d, 32'(o_out[d]),    32'd0);
      chk("R req",    d, 32'(o_req[d]),    32'd0);
      chk("R m0gnt",  d, 32'(o_m0_gnt[d]), 32'd0);
      chk("R m1gnt",  d, 32'(o_m1_gnt[d]), 32'd0);
    end
    step();
    rst_n = 1'b1;
    idle(); rvalid = 1'b1; rdata = 32'h77;
    at_neg();
    chk("R stray m0", 0, 32'(o_m0_rv[0]), 32'd0);
    chk("R stray m1", 0, 32'(o_m1_rv[0]), 32'd0);
    step();
    idle();
    at_neg();
    chk("R out0",     0, 32'(o_out[0]),   32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
